// File: rtl/reg_dumper_if.sv
// Clock and reset bundle shared by the register dumper and its surroundings.
interface reg_dumper_if;
    logic clk;
    logic reset;

    modport dut (input clk, input reset);
endinterface

// File: rtl/reg_dumper.sv
// Streams a wrapping range of register-file words out as valid/ready beats with a running checksum.
// Latency: start -> first beat valid in 2 cycles; one beat per 2 cycles at full rate; done 1 cycle after last accept.
// Backpressure: a beat holds out_data/out_idx/out_last and the checksum until out_ready; busy stalls CPU writes.
module reg_dumper #(
    parameter int CHK_ADD = 0
) (
    reg_dumper_if.dut   ctrl_bus,
    input  logic        start,
    input  logic [4:0]  first_reg,
    input  logic [4:0]  last_reg,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_idx,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic [31:0] checksum
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CAPTURE = 2'd1;
    localparam logic [1:0] SEND    = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]  state;
    logic [4:0]  idx;
    logic [4:0]  last_q;
    logic [31:0] chk_next;

    assign chk_next = (CHK_ADD != 0) ? (checksum + out_data) : (checksum ^ out_data);

    // The read port is parked at 0 outside CAPTURE so the regfile sees a quiet address.
    assign rd_addr   = (state == CAPTURE) ? idx : 5'd0;
    assign out_valid = (state == SEND);
    assign out_last  = (state == SEND) && (out_idx == last_q);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_ff @(posedge ctrl_bus.clk) begin
        if (ctrl_bus.reset) begin
            state    <= IDLE;
            idx      <= 5'd0;
            last_q   <= 5'd0;
            out_data <= 32'd0;
            out_idx  <= 5'd0;
            checksum <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx      <= first_reg;
                        last_q   <= last_reg;
                        checksum <= 32'd0;
                        state    <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    out_data <= rd_data;
                    out_idx  <= idx;
                    state    <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        checksum <= chk_next;
                        if (idx == last_q) begin
                            state <= DONE;
                        end else begin
                            // 5-bit increment wraps 31 -> 0 for ranges that cross the top.
                            idx   <= idx + 5'd1;
                            state <= CAPTURE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dumper.sv
// Bench for reg_dumper: XOR and additive checksum variants side by side against a queue-free range model.
module tb_reg_dumper;

    reg_dumper_if ctrl_bus ();

    logic        start;
    logic [4:0]  first_reg;
    logic [4:0]  last_reg;
    logic        out_ready;
    logic [31:0] rf [32];

    logic [4:0]  rd_addr0, rd_addr1;
    logic [31:0] rd_data0, rd_data1;
    logic        out_valid0, out_valid1;
    logic [31:0] out_data0, out_data1;
    logic [4:0]  out_idx0, out_idx1;
    logic        out_last0, out_last1;
    logic        busy0, busy1;
    logic        done0, done1;
    logic [31:0] checksum0, checksum1;

    int n_vec = 0;
    int n_err = 0;

    assign rd_data0 = rf[rd_addr0];
    assign rd_data1 = rf[rd_addr1];

    reg_dumper #(.CHK_ADD(0)) dut_xor (
        .ctrl_bus (ctrl_bus),
        .start    (start),
        .first_reg(first_reg),
        .last_reg (last_reg),
        .rd_addr  (rd_addr0),
        .rd_data  (rd_data0),
        .out_valid(out_valid0),
        .out_ready(out_ready),
        .out_data (out_data0),
        .out_idx  (out_idx0),
        .out_last (out_last0),
        .busy     (busy0),
        .done     (done0),
        .checksum (checksum0)
    );

    reg_dumper #(.CHK_ADD(1)) dut_add (
        .ctrl_bus (ctrl_bus),
        .start    (start),
        .first_reg(first_reg),
        .last_reg (last_reg),
        .rd_addr  (rd_addr1),
        .rd_data  (rd_data1),
        .out_valid(out_valid1),
        .out_ready(out_ready),
        .out_data (out_data1),
        .out_idx  (out_idx1),
        .out_last (out_last1),
        .busy     (busy1),
        .done     (done1),
        .checksum (checksum1)
    );

    initial ctrl_bus.clk = 1'b0;
    always #5 ctrl_bus.clk = ~ctrl_bus.clk;

    task automatic tick();
        @(posedge ctrl_bus.clk);
        #1;
    endtask

    task automatic fill_random();
        rf[0] = 32'd0;
        for (int i = 1; i < 32; i++) rf[i] = $urandom;
    endtask

    // One complete dump with per-cycle checks. stall_first forces that many not-ready cycles on beat 0;
    // stall_pct adds random not-ready cycles; extra_start pulses start while the dump is busy.
    task automatic do_dump(input logic [4:0] f, input logic [4:0] l, input int stall_first,
                           input int stall_pct, input bit extra_start,
                           output logic [31:0] cs_x, output logic [31:0] cs_a);
        int n;
        logic [4:0]  e_idx;
        logic [31:0] e_dat;
        bit rdy;
        int stalls;
        n = ((int'(l) - int'(f)) % 32 + 32) % 32 + 1;
        cs_x = 32'd0;
        cs_a = 32'd0;
        start = 1'b1; first_reg = f; last_reg = l; out_ready = 1'b0;
        tick();
        start = 1'b0; first_reg = 5'($urandom); last_reg = 5'($urandom);
        for (int k = 0; k < n; k++) begin
            e_idx = 5'((int'(f) + k) % 32);
            e_dat = rf[e_idx];
            n_vec++;
            if ({busy0, out_valid0, done0, rd_addr0} !== {1'b1, 1'b0, 1'b0, e_idx}) begin
                n_err++;
                $display("FAIL capture k=%0d: busy/valid/done/rd_addr=%b%b%b/%0d want 100/%0d",
                         k, busy0, out_valid0, done0, rd_addr0, e_idx);
            end
            tick();
            stalls = 0;
            forever begin
                n_vec++;
                if ({out_valid0, out_idx0, out_data0, out_last0, rd_addr0, done0} !==
                    {1'b1, e_idx, e_dat, (k == n - 1), 5'd0, 1'b0}) begin
                    n_err++;
                    $display("FAIL beat k=%0d: v=%b idx=%0d dat=%h last=%b ra=%0d done=%b want idx=%0d dat=%h last=%b",
                             k, out_valid0, out_idx0, out_data0, out_last0, rd_addr0, done0,
                             e_idx, e_dat, (k == n - 1));
                end
                n_vec++;
                if ({checksum0, checksum1, out_data1, out_idx1} !== {cs_x, cs_a, e_dat, e_idx}) begin
                    n_err++;
                    $display("FAIL send_chk k=%0d: xor=%h add=%h d1=%h i1=%0d want %h %h %h %0d",
                             k, checksum0, checksum1, out_data1, out_idx1, cs_x, cs_a, e_dat, e_idx);
                end
                if (k == 0 && stalls < stall_first) rdy = 1'b0;
                else if (stalls >= 8) rdy = 1'b1;
                else rdy = ($urandom_range(99) >= stall_pct);
                out_ready = rdy;
                if (extra_start) begin
                    start = 1'b1; first_reg = 5'($urandom); last_reg = 5'($urandom);
                end
                tick();
                out_ready = 1'b0;
                start = 1'b0;
                if (rdy) break;
                stalls++;
            end
            cs_x = cs_x ^ e_dat;
            cs_a = cs_a + e_dat;
        end
        n_vec++;
        if ({done0, done1, busy0, out_valid0, checksum0, checksum1} !== {1'b1, 1'b1, 1'b1, 1'b0, cs_x, cs_a}) begin
            n_err++;
            $display("FAIL done_cycle: done=%b%b busy=%b v=%b xor=%h add=%h want 11 1 0 %h %h",
                     done0, done1, busy0, out_valid0, checksum0, checksum1, cs_x, cs_a);
        end
        if (extra_start) start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if ({done0, done1, busy0, busy1, out_valid0, checksum0, checksum1} !==
                {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cs_x, cs_a}) begin
                n_err++;
                $display("FAIL idle_hold c=%0d: done=%b%b busy=%b%b v=%b xor=%h add=%h want %h %h",
                         c, done0, done1, busy0, busy1, out_valid0, checksum0, checksum1, cs_x, cs_a);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        ctrl_bus.reset = 1'b1; start = 1'b1; first_reg = 5'd3; last_reg = 5'd9; out_ready = 1'b1;
        tick();
        tick();
        n_vec++;
        if ({busy0, done0, out_valid0, out_last0, out_idx0, out_data0, checksum0, rd_addr0} !== 48'd0 ||
            {busy1, done1, out_valid1, out_last1, out_idx1, out_data1, checksum1, rd_addr1} !== 48'd0) begin
            n_err++;
            $display("FAIL reset_state: dut_xor b=%b d=%b v=%b l=%b i=%0d dat=%h cs=%h ra=%0d want all zero",
                     busy0, done0, out_valid0, out_last0, out_idx0, out_data0, checksum0, rd_addr0);
        end
        ctrl_bus.reset = 1'b0; start = 1'b0; out_ready = 1'b0;
        tick();
        n_vec++;
        if ({busy0, out_valid0, rd_addr0} !== 7'd0) begin
            n_err++;
            $display("FAIL reset_release: busy=%b v=%b ra=%0d want 0", busy0, out_valid0, rd_addr0);
        end
    endtask

    task automatic test_basic();
        logic [31:0] cx, ca;
        fill_random();
        rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'h44;
        do_dump(5'd1, 5'd3, 0, 0, 1'b0, cx, ca);
        n_vec++;
        if (checksum0 !== 32'h77) begin
            n_err++;
            $display("FAIL basic_xor: checksum=%h want 00000077", checksum0);
        end
        rf[1] = 32'hFFFF_FFFF; rf[2] = 32'h1; rf[3] = 32'h1;
        do_dump(5'd1, 5'd3, 0, 0, 1'b0, cx, ca);
        n_vec++;
        if (checksum1 !== 32'h1) begin
            n_err++;
            $display("FAIL basic_add_wrap: checksum=%h want 00000001", checksum1);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] cx, ca;
        fill_random();
        do_dump(5'd30, 5'd1, 0, 0, 1'b0, cx, ca);
        do_dump(5'd7, 5'd6, 0, 20, 1'b0, cx, ca);
    endtask

    task automatic test_backpressure();
        logic [31:0] cx, ca;
        fill_random();
        do_dump(5'd12, 5'd15, 5, 0, 1'b0, cx, ca);
    endtask

    task automatic test_single_second_start();
        logic [31:0] cx, ca;
        fill_random();
        do_dump(5'd5, 5'd5, 2, 0, 1'b1, cx, ca);
    endtask

    task automatic test_random();
        logic [31:0] cx, ca;
        for (int t = 0; t < 15; t++) begin
            fill_random();
            do_dump(5'($urandom), 5'($urandom), 0, 30, t[0], cx, ca);
        end
    endtask

    task automatic test_reset_mid();
        fill_random();
        start = 1'b1; first_reg = 5'd10; last_reg = 5'd13; out_ready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        n_vec++;
        if ({out_valid0, out_idx0, out_data0} !== {1'b1, 5'd11, rf[11]}) begin
            n_err++;
            $display("FAIL reset_mid_setup: v=%b idx=%0d dat=%h want 1 11 %h", out_valid0, out_idx0, out_data0, rf[11]);
        end
        ctrl_bus.reset = 1'b1; out_ready = 1'b1; start = 1'b1;
        tick();
        ctrl_bus.reset = 1'b0; out_ready = 1'b0; start = 1'b0;
        n_vec++;
        if ({busy0, out_valid0, done0, checksum0, busy1, out_valid1, done1, checksum1, out_idx0, out_data0} !== 109'd0) begin
            n_err++;
            $display("FAIL reset_mid: busy=%b v=%b done=%b xor=%h add=%h idx=%0d dat=%h want all zero",
                     busy0, out_valid0, done0, checksum0, checksum1, out_idx0, out_data0);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            n_vec++;
            if ({done0, out_valid0, busy0, done1} !== 4'd0) begin
                n_err++;
                $display("FAIL reset_mid_after c=%0d: done=%b v=%b busy=%b want 0", c, done0, out_valid0, busy0);
            end
        end
    endtask

    initial begin
        ctrl_bus.reset = 1'b1;
        start = 1'b0; first_reg = 5'd0; last_reg = 5'd0; out_ready = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_single_second_start();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
